// File: rtl/or_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : or_result_packer
//  Purpose  : Pops single result bits from the upstream OR stage and packs
//             them into words of a run-time programmable length. Finished
//             words go into a small FIFO that feeds the next stage through a
//             ready/enable pop interface.
//
//  Ports    : CLK, RST        - clock, synchronous active-high reset
//             y_data/y_rdy    - upstream bit and its availability
//             y_en            - pop strobe to upstream (y_rdy & !full & !RST)
//             len_value/len_en- requested word length, method enable
//             len_rdy         - length may be changed (no partial word)
//             dout_en         - downstream pops the head word
//             dout_value      - head word (0 when FIFO empty)
//             dout_rdy        - FIFO non-empty
//
//  Options  : OR_PACKER_MSB_FIRST_EN - when defined, the first bit of a word
//             lands at position L-1 and the last at position 0; otherwise
//             the k-th bit of a word lands at position k.
//
//  Revision : 1.0 - initial release
// ============================================================================
module or_result_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             y_data,
    input  logic             y_rdy,
    output logic             y_en,
    input  logic [LW-1:0]    len_value,
    input  logic             len_en,
    output logic             len_rdy,
    input  logic             dout_en,
    output logic [WIDTH-1:0] dout_value,
    output logic             dout_rdy
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    localparam logic [LW-1:0] c_WIDTH_LW = LW'(WIDTH);
    localparam logic [LW-1:0] c_ONE_LW   = LW'(1);
    localparam logic [CW-1:0] c_ONE_CW   = CW'(1);
    localparam logic [PW-1:0] c_ONE_PW   = PW'(1);
    localparam logic [OW-1:0] c_ONE_OW   = OW'(1);
    localparam logic [OW-1:0] c_DEPTH_OW = OW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LW-1:0]    len_q,    len_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]    occ_q,    occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic             w_full;
    logic             w_empty;
    logic             w_len_take;
    logic [LW-1:0]    w_len_clamped;
    logic [LW-1:0]    w_len_eff;
    logic             w_last;
    logic [WIDTH-1:0] w_word;
    logic             w_push;
    logic             w_pop;

    assign w_full   = (occ_q == c_DEPTH_OW);
    assign w_empty  = (occ_q == '0);

    assign y_en     = y_rdy & ~w_full & ~RST;
    assign len_rdy  = (count_q == '0);
    assign dout_rdy = ~w_empty;
    assign dout_value = w_empty ? '0 : mem_q[rd_ptr_q];

    // Zero and oversize requests both mean "full width".
    always_comb begin
        w_len_clamped = len_value;
        if ((len_value == '0) || (len_value > c_WIDTH_LW)) begin
            w_len_clamped = c_WIDTH_LW;
        end
    end

    // A request arriving at count 0 already governs the bit accepted on the
    // same edge; a blocked request must not influence word completion.
    assign w_len_take = len_en & len_rdy;
    assign w_len_eff  = w_len_take ? w_len_clamped : len_q;
    assign w_last     = ({1'b0, count_q} == (w_len_eff - c_ONE_LW));

    // Partial word including the bit being accepted this cycle.
`ifdef OR_PACKER_MSB_FIRST_EN
    assign w_word = {shreg_q[WIDTH-2:0], y_data};
`else
    always_comb begin
        w_word          = shreg_q;
        w_word[count_q] = y_data;
    end
`endif

    assign w_push = y_en & w_last;
    assign w_pop  = dout_en & ~w_empty;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        len_d    = len_q;
        count_d  = count_q;
        shreg_d  = shreg_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;

        if (w_len_take) begin
            len_d = w_len_clamped;
        end

        if (y_en) begin
            if (w_last) begin
                count_d = '0;
                shreg_d = '0;
            end else begin
                count_d = count_q + c_ONE_CW;
                shreg_d = w_word;
            end
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ONE_PW;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ONE_PW;
        end

        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + c_ONE_OW;
            2'b01:   occ_d = occ_q - c_ONE_OW;
            default: occ_d = occ_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_q    <= c_WIDTH_LW;
            count_q  <= '0;
            shreg_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            len_q    <= len_d;
            count_q  <= count_d;
            shreg_q  <= shreg_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: contents are only visible while occupied, and
    // w_push is already blocked during reset through y_en.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_or_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_or_result_packer
//  Purpose  : Self-checking bench for or_result_packer (WIDTH=8, DEPTH=4).
//             Directed vector table, hand-written corner sequences, and a
//             randomized run against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_or_result_packer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 4;

`ifdef OR_PACKER_MSB_FIRST_EN
    localparam logic [7:0] c_W1  = 8'hB2;
    localparam logic [7:0] c_W2  = 8'h06;
    localparam logic [7:0] c_WBK = 8'hD6;
    localparam bit         c_MSB = 1'b1;
`else
    localparam logic [7:0] c_W1  = 8'h4D;
    localparam logic [7:0] c_W2  = 8'h03;
    localparam logic [7:0] c_WBK = 8'h6B;
    localparam bit         c_MSB = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             y_data;
    logic             y_rdy;
    logic             y_en;
    logic [LW-1:0]    len_value;
    logic             len_en;
    logic             len_rdy;
    logic             dout_en;
    logic [WIDTH-1:0] dout_value;
    logic             dout_rdy;

    or_result_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .y_data     (y_data),
        .y_rdy      (y_rdy),
        .y_en       (y_en),
        .len_value  (len_value),
        .len_en     (len_en),
        .len_rdy    (len_rdy),
        .dout_en    (dout_en),
        .dout_value (dout_value),
        .dout_rdy   (dout_rdy)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: bits of the word in progress, completed words, length.
    int m_len;
    int m_cur[$];
    int m_fifo[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_len = WIDTH;
        m_cur.delete();
        m_fifo.delete();
    endtask

    task automatic drive(input logic r, input logic yr, input logic yd,
                         input logic le, input logic [LW-1:0] lv, input logic de);
        RST = r; y_rdy = yr; y_data = yd; len_en = le; len_value = lv; dout_en = de;
    endtask

    // Check all outputs against the model, advance the model, then cross the edge.
    task automatic cycle();
        int  exp_yen;
        bit  do_pop;
        int  w;
        int  lv;
        #2;
        exp_yen = (y_rdy && (m_fifo.size() < DEPTH) && !RST) ? 1 : 0;
        chk("m_y_en",       y_en,     exp_yen);
        chk("m_len_rdy",    len_rdy,  (m_cur.size() == 0) ? 1 : 0);
        chk("m_dout_rdy",   dout_rdy, (m_fifo.size() > 0) ? 1 : 0);
        chk("m_dout_value", dout_value, (m_fifo.size() > 0) ? m_fifo[0] : 0);
        if (RST) begin
            model_reset();
        end else begin
            if (len_en && m_cur.size() == 0) begin
                lv    = int'(len_value);
                m_len = (lv == 0 || lv > WIDTH) ? WIDTH : lv;
            end
            do_pop = dout_en && (m_fifo.size() > 0);
            if (exp_yen == 1) begin
                m_cur.push_back(int'(y_data));
                if (m_cur.size() == m_len) begin
                    w = 0;
                    for (int k = 0; k < m_len; k++) begin
                        if (c_MSB) w = w | (m_cur[k] << (m_len - 1 - k));
                        else       w = w | (m_cur[k] << k);
                    end
                    m_fifo.push_back(w);
                    m_cur.delete();
                end
            end
            if (do_pop) void'(m_fifo.pop_front());
        end
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic       rst, yr, yd, le;
        logic [3:0] lv;
        logic       de;
        logic       ey, elr, edr;
        logic [7:0] edv;
    } row_t;

    row_t tbl[17];

    function automatic row_t mk(input logic r, yr, yd, le, input logic [3:0] lv,
                                input logic de, ey, elr, edr, input logic [7:0] edv);
        row_t t;
        t.rst = r; t.yr = yr; t.yd = yd; t.le = le; t.lv = lv; t.de = de;
        t.ey = ey; t.elr = elr; t.edr = edr; t.edv = edv;
        return t;
    endfunction

    initial begin
        logic [7:0] pat;

        // Default length 8, bits 1,0,1,1,0,0,1,0, then pop.
        tbl[0]  = mk(0,1,1,0,0,0, 1,1,0,8'h00);
        tbl[1]  = mk(0,1,0,0,0,0, 1,0,0,8'h00);
        tbl[2]  = mk(0,1,1,0,0,0, 1,0,0,8'h00);
        tbl[3]  = mk(0,1,1,0,0,0, 1,0,0,8'h00);
        tbl[4]  = mk(0,1,0,0,0,0, 1,0,0,8'h00);
        tbl[5]  = mk(0,1,0,0,0,0, 1,0,0,8'h00);
        tbl[6]  = mk(0,1,1,0,0,0, 1,0,0,8'h00);
        tbl[7]  = mk(0,1,0,0,0,0, 1,0,0,8'h00);
        tbl[8]  = mk(0,0,0,0,0,0, 0,1,1,c_W1);
        tbl[9]  = mk(0,0,0,0,0,1, 0,1,1,c_W1);
        tbl[10] = mk(0,0,0,0,0,0, 0,1,0,8'h00);
        // Length 3 loaded with the first bit, bits 1,1,0.
        tbl[11] = mk(0,1,1,1,3,0, 1,1,0,8'h00);
        tbl[12] = mk(0,1,1,0,0,0, 1,0,0,8'h00);
        tbl[13] = mk(0,1,0,0,0,0, 1,0,0,8'h00);
        tbl[14] = mk(0,0,0,0,0,0, 0,1,1,c_W2);
        tbl[15] = mk(0,0,0,0,0,1, 0,1,1,c_W2);
        tbl[16] = mk(0,0,0,1,8,0, 0,1,0,8'h00);

        drive(1,0,0,0,0,0);
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].yr, tbl[i].yd, tbl[i].le, tbl[i].lv, tbl[i].de);
            #1;
            chk($sformatf("tbl%0d_y_en", i),       y_en,       tbl[i].ey);
            chk($sformatf("tbl%0d_len_rdy", i),    len_rdy,    tbl[i].elr);
            chk($sformatf("tbl%0d_dout_rdy", i),   dout_rdy,   tbl[i].edr);
            chk($sformatf("tbl%0d_dout_value", i), dout_value, tbl[i].edv);
            cycle();
        end

        // Clamping: 0 and 12 both mean 8 bits.
        for (int c = 0; c < 2; c++) begin
            drive(0,1,1,1,(c == 0) ? 4'd0 : 4'd12,0);
            cycle();
            for (int k = 0; k < 6; k++) begin
                drive(0,1,1,0,0,0);
                cycle();
            end
            chk("clamp_early_dout_rdy", dout_rdy, 0);
            drive(0,1,1,0,0,0);
            cycle();
            chk("clamp_done_dout_rdy", dout_rdy, 1);
            chk("clamp_dout_value", dout_value, 8'hFF);
            drive(0,0,0,0,0,1);
            cycle();
        end

        // Full FIFO with one-bit words.
        drive(0,0,0,1,1,0);
        cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0,1,1,0,0,0);
            cycle();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0,1,1,0,0,0);
            #1;
            chk("full_y_en", y_en, 0);
            cycle();
        end
        drive(0,1,1,0,0,1);
        cycle();
        drive(0,1,1,0,0,0);
        #1;
        chk("refill_y_en", y_en, 1);
        cycle();
        drive(0,1,1,0,0,0);
        #1;
        chk("refull_y_en", y_en, 0);
        cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0,0,0,0,0,1);
            #1;
            chk("full_pop_value", dout_value, 8'h01);
            cycle();
        end
        chk("full_drained_dout_rdy", dout_rdy, 0);
        drive(0,0,0,1,8,0);
        cycle();

        // Blocked length request at count 3.
        pat = 8'b0110_1011;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                drive(0,1,pat[k],1,2,0);
                #1;
                chk("blk_len_rdy", len_rdy, 0);
            end else begin
                drive(0,1,pat[k],0,0,0);
            end
            cycle();
            if (k == 6) chk("blk_early_dout_rdy", dout_rdy, 0);
        end
        chk("blk_dout_rdy", dout_rdy, 1);
        chk("blk_dout_value", dout_value, c_WBK);
        drive(0,0,0,0,0,1);
        cycle();

        // Reset in the middle of a word.
        for (int k = 0; k < 5; k++) begin
            drive(0,1,1,0,0,0);
            cycle();
        end
        drive(1,1,1,0,0,0);
        cycle();
        chk("rst_dout_rdy", dout_rdy, 0);
        chk("rst_len_rdy", len_rdy, 1);
        for (int k = 0; k < 8; k++) begin
            drive(0,1,1,0,0,0);
            cycle();
        end
        chk("rst_word_dout_rdy", dout_rdy, 1);
        chk("rst_word_value", dout_value, 8'hFF);
        drive(0,0,0,0,0,1);
        cycle();
        chk("rst_single_word", dout_rdy, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom),
                  ($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
